// File: rtl/router_dest_fifo.sv
// rtl/router_dest_fifo.sv - packet-aware output buffer for one router destination port
module router_dest_fifo #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int LEN_LSB = 2,
  parameter int TIMEOUT = 30
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_enb,
  output logic [DATA_W-1:0] data_out,
  output logic              vld_out,
  output logic              full,
  output logic              empty,
  output logic              pkt_done,
  output logic              timeout_drop
);

  localparam int PW     = $clog2(DEPTH);
  localparam int LEN_W  = DATA_W - LEN_LSB;
  localparam int CNT_W  = LEN_W + 2;
  localparam int IDLE_W = $clog2(TIMEOUT) + 1;

  localparam logic [PW:0]       PTR_ONE  = 1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
  localparam logic [IDLE_W-1:0] IDLE_ONE = 1;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);

  // Each entry carries the header tag above the data byte.
  logic [DATA_W:0]     mem_q [DEPTH];

  logic [PW:0]         wr_ptr_q, wr_ptr_d;
  logic [PW:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                pkt_done_q, pkt_done_d;
  logic                timeout_drop_q, timeout_drop_d;

  logic                do_wr;
  logic                do_rd;
  logic                idle;
  logic                flush;
  logic [DATA_W:0]     rd_word;
  logic [LEN_W-1:0]    rd_len;

  // Status flags come straight from the registered pointers.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign vld_out = !empty;

  // The destination is idle when data waits and nobody asks for it.
  assign idle    = vld_out && !read_enb;
  assign flush   = idle && (idle_cnt_q == IDLE_MAX);

  // A flush discards everything, so a write in the same cycle is lost too.
  assign do_wr   = write_enb && !full && !flush;
  assign do_rd   = read_enb && !empty;

  assign rd_word = mem_q[rd_ptr_q[PW-1:0]];
  assign rd_len  = rd_word[DATA_W-1:LEN_LSB];

  // Next-state for pointers, packet tracking, idle timer and registered outputs.
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    byte_cnt_d     = byte_cnt_q;
    idle_cnt_d     = idle_cnt_q;
    data_out_d     = data_out_q;
    pkt_done_d     = 1'b0;
    timeout_drop_d = 1'b0;
    if (flush) begin
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      byte_cnt_d     = '0;
      idle_cnt_d     = '0;
      data_out_d     = '0;
      timeout_drop_d = 1'b1;
    end else begin
      if (do_wr) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_rd) begin
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
        data_out_d = rd_word[DATA_W-1:0];
        if (rd_word[DATA_W]) begin
          // Header: count payload plus the trailing parity byte.
          byte_cnt_d = {2'b00, rd_len} + CNT_ONE;
        end else if (byte_cnt_q != '0) begin
          byte_cnt_d = byte_cnt_q - CNT_ONE;
          pkt_done_d = (byte_cnt_q == CNT_ONE);
        end
      end
      idle_cnt_d = idle ? (idle_cnt_q + IDLE_ONE) : '0;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      byte_cnt_q     <= '0;
      idle_cnt_q     <= '0;
      data_out_q     <= '0;
      pkt_done_q     <= 1'b0;
      timeout_drop_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      byte_cnt_q     <= byte_cnt_d;
      idle_cnt_q     <= idle_cnt_d;
      data_out_q     <= data_out_d;
      pkt_done_q     <= pkt_done_d;
      timeout_drop_q <= timeout_drop_d;
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clock) begin
    if (!reset && do_wr) begin
      mem_q[wr_ptr_q[PW-1:0]] <= {lfd_state, data_in};
    end
  end

  assign data_out     = data_out_q;
  assign pkt_done     = pkt_done_q;
  assign timeout_drop = timeout_drop_q;

endmodule

// File: tb/tb_router_dest_fifo.sv
// tb/tb_router_dest_fifo.sv - scoreboard bench for router_dest_fifo
module tb_router_dest_fifo;

  logic       clock;
  logic       reset;
  logic       write_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic       read_enb;
  logic [7:0] data_out;
  logic       vld_out;
  logic       full;
  logic       empty;
  logic       pkt_done;
  logic       timeout_drop;

  int checks = 0;
  int errors = 0;

  // Expected read results: {pkt_done, data}
  logic [8:0] exp_q[$];
  logic       fire_q = 1'b0;

  router_dest_fifo #(.DATA_W(8), .DEPTH(16), .LEN_LSB(2), .TIMEOUT(30)) dut (
    .clock(clock), .reset(reset), .write_enb(write_enb), .lfd_state(lfd_state),
    .data_in(data_in), .read_enb(read_enb), .data_out(data_out), .vld_out(vld_out),
    .full(full), .empty(empty), .pkt_done(pkt_done), .timeout_drop(timeout_drop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic lfd, input logic [7:0] d);
    write_enb = 1'b1;
    lfd_state = lfd;
    data_in   = d;
    tick();
    write_enb = 1'b0;
    lfd_state = 1'b0;
  endtask

  task automatic rd(input logic [7:0] d, input logic done);
    read_enb = 1'b1;
    exp_q.push_back({done, d});
    tick();
    read_enb = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Note which edges accept a read.
  always @(posedge clock) fire_q <= read_enb && vld_out && !reset;

  // Compare each presented byte against the scoreboard.
  always @(negedge clock) begin
    if (fire_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected_read data=%0h pkt_done=%0b", data_out, pkt_done);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("mon_data", data_out, e[7:0]);
        chk("mon_pkt_done", pkt_done, e[8]);
      end
    end else begin
      chk("mon_pkt_done_idle", pkt_done, 0);
    end
  end

  initial begin
    reset = 1'b1; write_enb = 1'b0; lfd_state = 1'b0; data_in = 8'h00; read_enb = 1'b0;
    tick(); tick();
    chk("rst_data_out", data_out, 0);
    chk("rst_vld_out", vld_out, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_timeout_drop", timeout_drop, 0);
    reset = 1'b0;
    tick();

    // 1: header 0C (len 3), payload, parity; back-to-back reads
    wr(1'b1, 8'h0C); wr(1'b0, 8'h11); wr(1'b0, 8'h22); wr(1'b0, 8'h33); wr(1'b0, 8'h5A);
    read_enb = 1'b1;
    exp_q.push_back({1'b0, 8'h0C}); tick();
    exp_q.push_back({1'b0, 8'h11}); tick();
    exp_q.push_back({1'b0, 8'h22}); tick();
    exp_q.push_back({1'b0, 8'h33}); tick();
    exp_q.push_back({1'b1, 8'h5A}); tick();
    read_enb = 1'b0;
    chk("t1_empty", empty, 1);
    tick();

    // 2: fill, overflow dropped, drain in order
    for (int i = 0; i < 16; i++) wr(1'b0, 8'(i));
    chk("t2_full", full, 1);
    wr(1'b0, 8'hFF);
    chk("t2_full_after_drop", full, 1);
    read_enb = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({1'b0, 8'(i)});
      tick();
    end
    read_enb = 1'b0;
    chk("t2_empty", empty, 1);

    // 3: simultaneous read+write at full, then at empty
    for (int i = 0; i < 16; i++) wr(1'b0, 8'hA0 + 8'(i));
    chk("t3_full", full, 1);
    write_enb = 1'b1; data_in = 8'h77; read_enb = 1'b1;
    exp_q.push_back({1'b0, 8'hA0});
    tick();
    write_enb = 1'b0; read_enb = 1'b0;
    chk("t3_not_full", full, 0);
    read_enb = 1'b1;
    for (int i = 1; i < 16; i++) begin
      exp_q.push_back({1'b0, 8'hA0 + 8'(i)});
      tick();
    end
    read_enb = 1'b0;
    chk("t3_empty_write_dropped", empty, 1);
    write_enb = 1'b1; data_in = 8'h55; read_enb = 1'b1;
    tick();
    write_enb = 1'b0; read_enb = 1'b0;
    chk("t3_vld_after_empty_rw", vld_out, 1);
    chk("t3_data_out_held", data_out, 8'hAF);
    rd(8'h55, 1'b0);
    chk("t3_empty_end", empty, 1);

    // 4: one byte left unread -> flush at edge 30
    wr(1'b0, 8'h99);
    idle(29);
    chk("t4_no_drop_29", timeout_drop, 0);
    chk("t4_vld_29", vld_out, 1);
    tick();
    chk("t4_drop", timeout_drop, 1);
    chk("t4_empty", empty, 1);
    chk("t4_vld", vld_out, 0);
    chk("t4_data_out", data_out, 0);
    tick();
    chk("t4_drop_pulse", timeout_drop, 0);

    // 5: read just before timeout, then timer restarts from zero
    wr(1'b0, 8'h42);
    idle(29);
    rd(8'h42, 1'b0);
    chk("t5_no_drop", timeout_drop, 0);
    chk("t5_empty", empty, 1);
    wr(1'b0, 8'h43);
    idle(29);
    chk("t5_restart_no_drop", timeout_drop, 0);
    chk("t5_restart_vld", vld_out, 1);
    tick();
    chk("t5_restart_drop", timeout_drop, 1);
    tick();

    // 6: reset mid-packet, then a fresh packet
    wr(1'b1, 8'h08); wr(1'b0, 8'h10);
    rd(8'h08, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_empty", empty, 1);
    chk("t6_data_out", data_out, 0);
    chk("t6_vld", vld_out, 0);
    wr(1'b1, 8'h04); wr(1'b0, 8'h21); wr(1'b0, 8'h25);
    read_enb = 1'b1;
    exp_q.push_back({1'b0, 8'h04}); tick();
    exp_q.push_back({1'b0, 8'h21}); tick();
    exp_q.push_back({1'b1, 8'h25}); tick();
    read_enb = 1'b0;
    chk("t6_empty_end", empty, 1);
    tick(); tick();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
